// File: rtl/toggle_sync_rx.sv
// Receive side of the two-phase toggle handshake: synchronizes req_tog_i, captures data_i,
// and returns ack_tog once the word is consumed. Define TOGGLE_SYNC_RX_OVERRUN_EN for overrun detection.
module toggle_sync_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_tog_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_ready,
    input  logic                  cnt_clr,
    output logic                  ack_tog,
    output logic                  pulse,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid,
    output logic [CNT_WIDTH-1:0]  event_cnt,
    output logic                  overrun
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   det;
    state_t                 state_reg;
    logic                   ack_reg;
    logic                   pulse_reg;
    logic [DATA_WIDTH-1:0]  data_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;

    // First stage samples the asynchronous toggle; later stages only resolve metastability.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= req_tog_i;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign det = sync_reg[SYNC_STAGES-1] ^ prev_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            prev_reg  <= sync_reg[SYNC_STAGES-1];
            pulse_reg <= det;
            if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (det && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Handshake FSM; a det in FULL without data_ready is a protocol violation and never touches data_reg.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= EMPTY;
            ack_reg   <= 1'b0;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (det) begin
                        data_reg  <= data_i;
                        state_reg <= FULL;
                    end
                end
                FULL: begin
                    if (data_ready) begin
                        ack_reg <= ~ack_reg;
                        if (det) begin
                            data_reg <= data_i;
                        end else begin
                            state_reg <= EMPTY;
                        end
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

`ifdef TOGGLE_SYNC_RX_OVERRUN_EN
    logic overrun_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun_reg <= 1'b0;
        end else if ((state_reg == FULL) && det && !data_ready) begin
            overrun_reg <= 1'b1;
        end
    end

    assign overrun = overrun_reg;
`else
    assign overrun = 1'b0;
`endif

    assign ack_tog    = ack_reg;
    assign pulse      = pulse_reg;
    assign data_o     = data_reg;
    assign data_valid = (state_reg == FULL);
    assign event_cnt  = cnt_reg;

endmodule
